// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// One operation in flight; round-robin on contention.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_aluop,
    input  logic [3:0]  req0_func,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_aluop,
    input  logic [3:0]  req1_func,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic [1:0]  alu_op,
    output logic [3:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] cnt;
    logic       last_id;
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       exec_done;
    logic       rsp_fire;

    // last_id resets to 1 so requester 0 wins the first contention.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_id;
                grant1 = !last_id;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign exec_done  = (state == EXEC) && (cnt == CNT_LAST);
    assign rsp_valid  = (state == RESP);
    assign rsp_fire   = rsp_valid && rsp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: if (exec_done) state_nxt = RESP;
            RESP: if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last_id <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= 4'd0;
            end else if (state == EXEC && !exec_done) begin
                cnt <= cnt + 4'd1;
            end
            if (rsp_fire) begin
                last_id <= rsp_id;
            end
        end
    end

    // Operand registers are the only source of the ALU inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op   <= 2'd0;
            alu_func <= 4'd0;
            alu_a    <= 32'd0;
            alu_b    <= 32'd0;
            rsp_id   <= 1'b0;
        end else if (accept) begin
            alu_op   <= grant1 ? req1_aluop : req0_aluop;
            alu_func <= grant1 ? req1_func  : req0_func;
            alu_a    <= grant1 ? req1_a     : req0_a;
            alu_b    <= grant1 ? req1_b     : req0_b;
            rsp_id   <= grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= 32'd0;
            rsp_zero <= 1'b0;
        end else if (exec_done) begin
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int EXEC_A = 1;
    localparam int EXEC_B = 4;

    logic clk;
    int   errors;
    int   checks;
    bit   last_served;

    // Instance A (EXEC_CYCLES=1)
    logic        rst_n;
    logic        r0v, r0r, r1v, r1r;
    logic [1:0]  r0op, r1op;
    logic [3:0]  r0f, r1f;
    logic [31:0] r0a, r0b, r1a, r1b;
    logic [1:0]  alu_op;
    logic [3:0]  alu_func;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_data;

    // Instance B (EXEC_CYCLES=4)
    logic        b_rst_n;
    logic        b_r0v, b_r0r, b_r1v, b_r1r;
    logic [1:0]  b_r0op, b_r1op;
    logic [3:0]  b_r0f, b_r1f;
    logic [31:0] b_r0a, b_r0b, b_r1a, b_r1b;
    logic [1:0]  b_alu_op;
    logic [3:0]  b_alu_func;
    logic [31:0] b_alu_a, b_alu_b, b_alu_out;
    logic        b_alu_zero;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_zero;
    logic [31:0] b_rsp_data;

    function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [3:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            default:
                case (f)
                    4'b0000: return a & b;
                    4'b0001: return a | b;
                    4'b0010: return a + b;
                    4'b0110: return a - b;
                    4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: return 32'd0;
                endcase
        endcase
    endfunction

    assign alu_out    = alu_fn(alu_op, alu_func, alu_a, alu_b);
    assign alu_zero   = (alu_out == 32'd0);
    assign b_alu_out  = alu_fn(b_alu_op, b_alu_func, b_alu_a, b_alu_b);
    assign b_alu_zero = (b_alu_out == 32'd0);

    alu_arbiter #(.EXEC_CYCLES(EXEC_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_aluop(r0op), .req0_func(r0f),
        .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_aluop(r1op), .req1_func(r1f),
        .req1_a(r1a), .req1_b(r1b),
        .alu_op(alu_op), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero)
    );

    alu_arbiter #(.EXEC_CYCLES(EXEC_B)) u_dut4 (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_aluop(b_r0op), .req0_func(b_r0f),
        .req0_a(b_r0a), .req0_b(b_r0b),
        .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_aluop(b_r1op), .req1_func(b_r1f),
        .req1_a(b_r1a), .req1_b(b_r1b),
        .alu_op(b_alu_op), .alu_func(b_alu_func), .alu_a(b_alu_a), .alu_b(b_alu_b),
        .alu_out(b_alu_out), .alu_zero(b_alu_zero),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_data(b_rsp_data), .rsp_zero(b_rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        r0v = 0; r0op = 0; r0f = 0; r0a = 0; r0b = 0;
        r1v = 0; r1op = 0; r1f = 0; r1a = 0; r1b = 0;
    endtask

    task automatic roll(output logic v, output logic [1:0] op, output logic [3:0] f,
                        output logic [31:0] a, output logic [31:0] b);
        logic [3:0] fs [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
        v  = ($urandom_range(0, 1) == 1);
        op = 2'($urandom_range(0, 3));
        f  = fs[$urandom_range(0, 4)];
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_zero, alu_op, alu_func, alu_a, alu_b} !== 108'd0) begin
            errors++;
            $display("FAIL reset_a: got valid=%b id=%b data=%h zero=%b op=%h f=%h a=%h b=%h want all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_zero, alu_op, alu_func, alu_a, alu_b);
        end
        checks++;
        if ({b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_zero, b_alu_op, b_alu_func, b_alu_a, b_alu_b} !== 108'd0) begin
            errors++;
            $display("FAIL reset_b: got data=%h a=%h want all 0", b_rsp_data, b_alu_a);
        end
        step();
        rst_n = 1; b_rst_n = 1;
        @(negedge clk);
        checks++;
        if ({r0r, r1r, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got r0r=%b r1r=%b rsp_valid=%b want 000", r0r, r1r, rsp_valid);
        end
        step();
        last_served = 1;
    endtask

    task automatic test_single();
        idle_a();
        r0v = 1; r0op = 2'b10; r0f = 4'b0010; r0a = 5; r0b = 7; rsp_ready = 1;
        @(negedge clk);
        checks++;
        if ({r0r, r1r} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got %b%b want 10", r0r, r1r);
        end
        step();
        r0v = 0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, r0r} !== 2'b00) begin
            errors++; $display("FAIL single_exec: got valid=%b ready=%b want 0 0", rsp_valid, r0r);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_zero} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b id=%b data=%0d zero=%b want 1 0 12 0",
                     rsp_valid, rsp_id, rsp_data, rsp_zero);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: got rsp_valid=%b want 0", rsp_valid);
        end
        step();
        last_served = 0;
    endtask

    task automatic test_zero();
        idle_a();
        r1v = 1; r1op = 2'b10; r1f = 4'b0110; r1a = 32'h9; r1b = 32'h9; rsp_ready = 1;
        @(negedge clk);
        checks++;
        if ({r0r, r1r} !== 2'b01) begin
            errors++; $display("FAIL zero_ready: got %b%b want 01", r0r, r1r);
        end
        step();
        r1v = 0;
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_zero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL zero_rsp: got valid=%b id=%b data=%h zero=%b want 1 1 0 1",
                     rsp_valid, rsp_id, rsp_data, rsp_zero);
        end
        step();
        last_served = 1;
    endtask

    task automatic test_input_change();
        idle_a();
        r0v = 1; r0op = 2'b00; r0a = 100; r0b = 1; rsp_ready = 1;
        @(negedge clk);
        checks++;
        if (r0r !== 1'b1) begin
            errors++; $display("FAIL chg_ready: got %b want 1", r0r);
        end
        step();
        r0v = 0; r0a = 555; r0b = 77; r0op = 2'b01;
        @(negedge clk);
        checks++;
        if ({alu_op, alu_a, alu_b} !== {2'b00, 32'd100, 32'd1}) begin
            errors++; $display("FAIL chg_alu: got op=%b a=%0d b=%0d want 0 100 1", alu_op, alu_a, alu_b);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'd101}) begin
            errors++; $display("FAIL chg_rsp: got valid=%b data=%0d want 1 101", rsp_valid, rsp_data);
        end
        step();
        last_served = 0;
    endtask

    task automatic test_backpressure();
        bit got;
        idle_a();
        r1v = 1; r1op = 2'b00; r1a = 32'h1234; r1b = 32'h1111; rsp_ready = 0;
        @(negedge clk);
        checks++;
        if (r1r !== 1'b1) begin
            errors++; $display("FAIL bp_ready: got %b want 1", r1r);
        end
        step();
        r1v = 0;
        r0v = 1; r0op = 2'b00; r0a = 1; r0b = 1;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) got = 1;
            else step();
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL bp_timeout: got no rsp_valid want 1 within 10 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_zero, r0r, r1r, alu_op, alu_a, alu_b} !==
                {1'b1, 1'b1, 32'h2345, 1'b0, 2'b00, 2'b00, 32'h1234, 32'h1111}) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b id=%b data=%h r0r=%b a=%h want 1 1 2345 0 1234",
                         i, rsp_valid, rsp_id, rsp_data, r0r, alu_a);
            end
            step();
            @(negedge clk);
        end
        step();
        rsp_ready = 1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, r0r} !== 2'b10) begin
            errors++; $display("FAIL bp_release: got valid=%b r0r=%b want 1 0", rsp_valid, r0r);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, r0r} !== 2'b01) begin
            errors++; $display("FAIL bp_next: got valid=%b r0r=%b want 0 1", rsp_valid, r0r);
        end
        step();
        r0v = 0;
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd2}) begin
            errors++; $display("FAIL bp_rsp2: got valid=%b id=%b data=%0d want 1 0 2", rsp_valid, rsp_id, rsp_data);
        end
        step();
        last_served = 0;
    endtask

    task automatic test_contention();
        int  served[$];
        bit  done;
        idle_a();
        rsp_ready = 1;
        rst_n = 0;
        step();
        rst_n = 1;
        last_served = 1;
        r0v = 1; r0op = 2'b00; r0a = 3; r0b = 4;
        r1v = 1; r1op = 2'b01; r1a = 9; r1b = 2;
        for (int c = 0; c < 40 && served.size() < 4; c++) begin
            @(negedge clk);
            checks++;
            if (r0r === 1'b1 && r1r === 1'b1) begin
                errors++; $display("FAIL cont_both: got both ready want one");
            end
            if (r0r === 1'b1) served.push_back(0);
            else if (r1r === 1'b1) served.push_back(1);
            step();
        end
        r0v = 0; r1v = 0;
        checks++;
        if (served.size() != 4) begin
            errors++; $display("FAIL cont_count: got %0d grants want 4", served.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (served[i] != i % 2) begin
                    errors++; $display("FAIL cont_order%0d: got %0d want %0d", i, served[i], i % 2);
                end
            end
        end
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) done = 1;
            step();
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL cont_drain: got no response want one");
        end
        last_served = 1;
    endtask

    task automatic test_random();
        bit          busy;
        bit          e_id;
        logic [1:0]  e_op;
        logic [3:0]  e_f;
        logic [31:0] e_a, e_b, e_data;
        logic        g0, g1;
        int          due;
        int          c;
        busy = 0; due = 0; c = 0;
        idle_a();
        while (c < 300 || (busy && c < 340)) begin
            if (c < 300) begin
                if ($urandom_range(0, 1) == 1) roll(r0v, r0op, r0f, r0a, r0b);
                if ($urandom_range(0, 1) == 1) roll(r1v, r1op, r1f, r1a, r1b);
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else begin
                r0v = 0; r1v = 0; rsp_ready = 1;
            end
            @(negedge clk);
            if (!busy) begin
                g0 = r0v && (!r1v || last_served);
                g1 = r1v && (!r0v || !last_served);
                checks++;
                if ({r0r, r1r, rsp_valid} !== {g0, g1, 1'b0}) begin
                    errors++;
                    $display("FAIL rnd_idle c=%0d: got r0r=%b r1r=%b valid=%b want %b %b 0",
                             c, r0r, r1r, rsp_valid, g0, g1);
                end
                if (g0 || g1) begin
                    busy = 1;
                    e_id = g1;
                    e_op = g1 ? r1op : r0op;
                    e_f  = g1 ? r1f : r0f;
                    e_a  = g1 ? r1a : r0a;
                    e_b  = g1 ? r1b : r0b;
                    e_data = alu_fn(e_op, e_f, e_a, e_b);
                    due = c + EXEC_A + 1;
                end
            end else begin
                checks++;
                if ({r0r, r1r, alu_op, alu_func, alu_a, alu_b} !== {2'b00, e_op, e_f, e_a, e_b}) begin
                    errors++;
                    $display("FAIL rnd_busy c=%0d: got r0r=%b r1r=%b a=%h b=%h want 0 0 %h %h",
                             c, r0r, r1r, alu_a, alu_b, e_a, e_b);
                end
                checks++;
                if (rsp_valid !== (c >= due)) begin
                    errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, rsp_valid, c >= due);
                end
                if (c >= due) begin
                    checks++;
                    if ({rsp_id, rsp_data, rsp_zero} !== {e_id, e_data, e_data == 32'd0}) begin
                        errors++;
                        $display("FAIL rnd_rsp c=%0d: got id=%b data=%h zero=%b want %b %h %b",
                                 c, rsp_id, rsp_data, rsp_zero, e_id, e_data, e_data == 32'd0);
                    end
                    if (rsp_ready) begin
                        busy = 0;
                        last_served = e_id;
                    end
                end
            end
            step();
            c++;
        end
        checks++;
        if (busy) begin
            errors++; $display("FAIL rnd_drain: got busy=1 want 0");
        end
        idle_a();
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        b_rsp_ready = 1;
        b_r0v = 1; b_r0op = 2'b00; b_r0a = 3; b_r0b = 4;
        @(negedge clk);
        checks++;
        if (b_r0r !== 1'b1) begin
            errors++; $display("FAIL rme_ready: got %b want 1", b_r0r);
        end
        step();
        b_r0v = 0;
        step();
        #2;
        b_rst_n = 0;
        #1;
        checks++;
        if ({b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_zero, b_alu_op, b_alu_func, b_alu_a, b_alu_b,
             b_r0r, b_r1r} !== 110'd0) begin
            errors++;
            $display("FAIL rme_zero: got valid=%b data=%h a=%h b=%h want all 0",
                     b_rsp_valid, b_rsp_data, b_alu_a, b_alu_b);
        end
        step();
        b_rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_rsp_valid !== 1'b0) seen = 1;
            step();
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rme_ghost: got rsp_valid=1 after reset want 0");
        end
        b_r0v = 1; b_r0op = 2'b01; b_r0a = 10; b_r0b = 10;
        b_r1v = 1; b_r1op = 2'b00; b_r1a = 1; b_r1b = 1;
        @(negedge clk);
        checks++;
        if ({b_r0r, b_r1r} !== 2'b10) begin
            errors++; $display("FAIL rme_prio: got %b%b want 10", b_r0r, b_r1r);
        end
        step();
        b_r0v = 0; b_r1v = 0;
        for (int k = 0; k < EXEC_B; k++) begin
            @(negedge clk);
            checks++;
            if ({b_rsp_valid, b_alu_a} !== {1'b0, 32'd10}) begin
                errors++; $display("FAIL rme_exec%0d: got valid=%b a=%0d want 0 10", k, b_rsp_valid, b_alu_a);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_zero} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL rme_rsp: got valid=%b id=%b data=%h zero=%b want 1 0 0 1",
                     b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_zero);
        end
        step();
    endtask

    initial begin
        errors = 0; checks = 0; last_served = 1;
        rst_n = 0; b_rst_n = 0;
        idle_a(); rsp_ready = 0;
        b_r0v = 0; b_r0op = 0; b_r0f = 0; b_r0a = 0; b_r0b = 0;
        b_r1v = 0; b_r1op = 0; b_r1f = 0; b_r1a = 0; b_r1b = 0;
        b_rsp_ready = 0;
        test_reset();
        test_single();
        test_zero();
        test_input_change();
        test_backpressure();
        test_contention();
        test_random();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
